// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: two-stage registered datapath with valid/ready handshakes.
// S1 holds the operands; S2 holds the computed result and flags.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_ctrl,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOR = 5'd5;
  localparam logic [4:0] OP_SLL = 5'd6;
  localparam logic [4:0] OP_SRL = 5'd7;
  localparam logic [4:0] OP_SRA = 5'd8;
  localparam logic [4:0] OP_SLT = 5'd9;

  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_ctrl_q, s1_ctrl_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_err_q, s2_err_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] sum, diff, res;
  logic [4:0]       shamt;
  logic             ovf, err, lt;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    sum   = s1_a_q + s1_b_q;
    diff  = s1_a_q - s1_b_q;
    shamt = s1_a_q[4:0];
    lt    = s1_sign_q ? ($signed(s1_a_q) < $signed(s1_b_q)) : (s1_a_q < s1_b_q);
    res   = '0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (s1_ctrl_q)
      OP_ADD: begin
        res = sum;
        ovf = s1_sign_q && (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
              (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = s1_sign_q && (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
              (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_AND: res = s1_a_q & s1_b_q;
      OP_OR:  res = s1_a_q | s1_b_q;
      OP_XOR: res = s1_a_q ^ s1_b_q;
      OP_NOR: res = ~(s1_a_q | s1_b_q);
      OP_SLL: res = s1_b_q << shamt;
      OP_SRL: res = s1_b_q >> shamt;
      OP_SRA: res = $signed(s1_b_q) >>> shamt;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      default: err = 1'b1;
    endcase
  end

  // S1 only ever loads when it is empty or draining into S2 this cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ctrl_d  = s1_ctrl_q;
    s1_sign_d  = s1_sign_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_ctrl_d = in_ctrl;
        s1_sign_d = in_sign;
        s1_a_d    = in_a;
        s1_b_d    = in_b;
      end
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_ovf_d    = s2_ovf_q;
    s2_err_d    = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_adv) begin
        s2_result_d = res;
        s2_zero_d   = (res == '0);
        s2_ovf_d    = ovf;
        s2_err_d    = err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s1_sign_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_sign_q   <= s1_sign_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_ovf    = s2_ovf_q;
  assign out_err    = s2_err_q;

endmodule
